hazard_stall_controller: RTL and testbench

- Parametrised successor to the ID-stage load-use detector.
- Adds multi-cycle load-use stalls, branch-in-ID operand hazards, x0 exemption, per-operand use qualification, data-memory busy freeze, and a saturating stall-cycle counter.
- Sits beside the ID stage.
- Drives the PC write enable, the IF/ID hold, the ID/EX bubble insertion and the global pipeline freeze.

---
 rtl/hazard_stall_controller.sv | 117 +++++++++++
 tb/tb_hazard_stall_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard controller: load-use, branch-operand and memory-busy stalls.
// Drives PC enable, IF/ID hold, ID/EX bubble, global freeze and a stall counter.
module hazard_stall_controller #(
  parameter int ADDR_W            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int ZERO_REG_EXEMPT   = 1,
  parameter int CNT_W             = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              RS1use_i,
  input  logic              RS2use_i,
  input  logic              ID_Branch_i,
  input  logic              ID_EX_MemRead_i,
  input  logic              ID_EX_RegWrite_i,
  input  logic [ADDR_W-1:0] ID_EX_RDaddr_i,
  input  logic              EX_MEM_MemRead_i,
  input  logic [ADDR_W-1:0] EX_MEM_RDaddr_i,
  input  logic              MemBusy_i,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic              Freeze_o,
  output logic [CNT_W-1:0]  StallCount_o
);

  typedef enum logic {
    IDLE,
    LU_WAIT
  } state_t;

  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic       MULTI    = (LOAD_STALL_CYCLES > 1);
  localparam logic       EXEMPT   = (ZERO_REG_EXEMPT != 0);

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hit_ex, hit_mem;
  logic lu, br_ex, br_mem;

  function automatic logic hit(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] rs1,
    input logic [ADDR_W-1:0] rs2,
    input logic              use1,
    input logic              use2
  );
    logic m;
    m = (use1 && (a == rs1)) || (use2 && (a == rs2));
    return m && !(EXEMPT && (a == '0));
  endfunction

  always_comb begin
    hit_ex  = hit(ID_EX_RDaddr_i, RS1addr_i, RS2addr_i,
                  RS1use_i, RS2use_i);
    hit_mem = hit(EX_MEM_RDaddr_i, RS1addr_i, RS2addr_i,
                  RS1use_i, RS2use_i);
    lu      = ID_EX_MemRead_i && hit_ex;
    br_ex   = ID_Branch_i && ID_EX_RegWrite_i && hit_ex;
    br_mem  = ID_Branch_i && EX_MEM_MemRead_i && hit_mem;
  end

  always_comb begin
    NoOp_o    = 1'b0;
    Stall_o   = 1'b0;
    PCWrite_o = 1'b1;
    Freeze_o  = 1'b0;
    state_d   = state_q;
    rem_d     = rem_q;
    if (!rst_i) begin
      state_d = IDLE;
    end else if (MemBusy_i) begin
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
      Freeze_o  = 1'b1;
    end else if (state_q == LU_WAIT) begin
      NoOp_o    = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
      rem_d     = rem_q - 4'd1;
      if (rem_q == 4'd1) state_d = IDLE;
    end else if (lu || br_ex || br_mem) begin
      NoOp_o    = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
      if (lu && MULTI) begin
        state_d = LU_WAIT;
        rem_d   = REM_INIT;
      end
    end
  end

  // Saturating: freeze cycles count as stalls too.
  always_comb begin
    cnt_d = cnt_q;
    if (Stall_o && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallCount_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench: three parameterisations driven in lockstep, checked against an
// "owed bubbles" model plus hand-computed literal expectations.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       use1, use2, br, ex_mr, ex_rw, mem_mr, busy;

  logic [2:0]  noop, stall, pcw, frz;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_chk  = 0;
  int n_fail = 0;

  // model configuration per instance: A, B, C
  int lsc  [3] = '{1, 3, 1};
  int zre  [3] = '{1, 1, 0};
  int cmax [3] = '{65535, 65535, 3};
  int owed [3];
  int mcnt [3];

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(1), .ZERO_REG_EXEMPT(1), .CNT_W(16)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(use1), .RS2use_i(use2),
    .ID_Branch_i(br), .ID_EX_MemRead_i(ex_mr),
    .ID_EX_RegWrite_i(ex_rw), .ID_EX_RDaddr_i(ex_rd),
    .EX_MEM_MemRead_i(mem_mr), .EX_MEM_RDaddr_i(mem_rd),
    .MemBusy_i(busy),
    .NoOp_o(noop[0]), .Stall_o(stall[0]),
    .PCWrite_o(pcw[0]), .Freeze_o(frz[0]),
    .StallCount_o(cnt_a)
  );

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(3), .ZERO_REG_EXEMPT(1), .CNT_W(16)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(use1), .RS2use_i(use2),
    .ID_Branch_i(br), .ID_EX_MemRead_i(ex_mr),
    .ID_EX_RegWrite_i(ex_rw), .ID_EX_RDaddr_i(ex_rd),
    .EX_MEM_MemRead_i(mem_mr), .EX_MEM_RDaddr_i(mem_rd),
    .MemBusy_i(busy),
    .NoOp_o(noop[1]), .Stall_o(stall[1]),
    .PCWrite_o(pcw[1]), .Freeze_o(frz[1]),
    .StallCount_o(cnt_b)
  );

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(1), .ZERO_REG_EXEMPT(0), .CNT_W(2)
  ) u_c (
    .clk_i(clk), .rst_i(rst),
    .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(use1), .RS2use_i(use2),
    .ID_Branch_i(br), .ID_EX_MemRead_i(ex_mr),
    .ID_EX_RegWrite_i(ex_rw), .ID_EX_RDaddr_i(ex_rd),
    .EX_MEM_MemRead_i(mem_mr), .EX_MEM_RDaddr_i(mem_rd),
    .MemBusy_i(busy),
    .NoOp_o(noop[2]), .Stall_o(stall[2]),
    .PCWrite_o(pcw[2]), .Freeze_o(frz[2]),
    .StallCount_o(cnt_c)
  );

  function automatic int dut_cnt(int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic bit hit(int i, logic [4:0] a);
    bit m;
    m = (use1 && a == rs1) || (use2 && a == rs2);
    return m && !(zre[i] != 0 && a == 5'd0);
  endfunction

  function automatic bit lu_hit(int i);
    return ex_mr && hit(i, ex_rd);
  endfunction

  function automatic bit any_hit(int i);
    return lu_hit(i) || (br && ex_rw && hit(i, ex_rd))
        || (br && mem_mr && hit(i, mem_rd));
  endfunction

  // expected {noop, stall, pcwrite, freeze}
  function automatic logic [3:0] model_out(int i);
    if (!rst)            return 4'b0010;
    if (busy)            return 4'b0101;
    if (owed[i] > 0)     return 4'b1100;
    if (any_hit(i))      return 4'b1100;
    return 4'b0010;
  endfunction

  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] o;
      o = model_out(i);
      if (!rst) begin
        owed[i] = 0;
        mcnt[i] = 0;
      end else begin
        if (!busy) begin
          if (owed[i] > 0) owed[i]--;
          else if (lu_hit(i)) owed[i] = lsc[i] - 1;
        end
        if (o[2] && mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] act, exp;
      act = {noop[i], stall[i], pcw[i], frz[i]};
      exp = model_out(i);
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs[%0d] t=%0t got=%b want=%b",
                 i, $time, act, exp);
      end
      n_chk++;
      if (dut_cnt(i) != mcnt[i]) begin
        n_fail++;
        $display("FAIL count[%0d] t=%0t got=%0d want=%0d",
                 i, $time, dut_cnt(i), mcnt[i]);
      end
    end
  endtask

  task automatic lit(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // inputs are applied just after negedge; outputs sampled 1ns later
  task automatic step();
    #1;
    check_all();
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 1'b1; busy = 1'b0;
    rs1 = 5'd1; rs2 = 5'd2; use1 = 1'b0; use2 = 1'b0;
    br = 1'b0; ex_mr = 1'b0; ex_rw = 1'b0; ex_rd = 5'd0;
    mem_mr = 1'b0; mem_rd = 5'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic load_use(logic [4:0] a);
    idle_in();
    ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = a;
    rs1 = a; use1 = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      owed[i] = 0;
      mcnt[i] = 0;
    end
    idle_in();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    lit("reset_cnt_a", int'(cnt_a), 0);
    lit("reset_pcw_a", int'(pcw[0]), 1);
    @(negedge clk);

    // single load-use, then pipeline moves on
    load_use(5'd5);
    #1;
    lit("lu_noop_a", int'(noop[0]), 1);
    lit("lu_pcw_b", int'(pcw[1]), 0);
    step();
    idle_in();
    for (int k = 0; k < 3; k++) step();
    lit("lu_cnt_a", int'(cnt_a), 1);
    lit("lu_cnt_b", int'(cnt_b), 3);

    // x0 destination and unused rs2
    do_reset();
    load_use(5'd0);
    #1;
    lit("x0_stall_a", int'(stall[0]), 0);
    lit("x0_stall_c", int'(stall[2]), 1);
    step();
    load_use(5'd6);
    use1 = 1'b0; rs1 = 5'd1; rs2 = 5'd6; use2 = 1'b0;
    #1;
    lit("rs2_unused_a", int'(stall[0]), 0);
    step();

    // branch: ALU producer in EX then load in MEM
    do_reset();
    idle_in();
    br = 1'b1; rs1 = 5'd7; use1 = 1'b1;
    ex_rw = 1'b1; ex_rd = 5'd7;
    step();
    ex_rw = 1'b0; ex_rd = 5'd0;
    mem_mr = 1'b1; mem_rd = 5'd7;
    #1;
    lit("br_mem_noop_a", int'(noop[0]), 1);
    step();
    idle_in();
    step();
    lit("br_cnt_a", int'(cnt_a), 2);

    // memory busy in the middle of the multi-cycle stall
    do_reset();
    load_use(5'd9);
    step();
    idle_in();
    step();
    busy = 1'b1;
    #1;
    lit("busy_frz_b", int'(frz[1]), 1);
    lit("busy_noop_b", int'(noop[1]), 0);
    step();
    step();
    busy = 1'b0;
    step();
    step();
    lit("busy_cnt_b", int'(cnt_b), 5);

    // reset while waiting
    do_reset();
    load_use(5'd4);
    step();
    idle_in();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    lit("rst_mid_stall_b", int'(stall[1]), 0);
    lit("rst_mid_cnt_b", int'(cnt_b), 0);
    step();

    // 2-bit counter saturates
    do_reset();
    load_use(5'd3);
    for (int k = 0; k < 5; k++) step();
    lit("sat_cnt_c", int'(cnt_c), 3);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 59) != 0);
      busy   = ($urandom_range(0, 7) == 0);
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      use1   = 1'($urandom);
      use2   = 1'($urandom);
      br     = 1'($urandom);
      ex_mr  = ($urandom_range(0, 2) == 0);
      ex_rw  = 1'($urandom);
      mem_mr = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
